// File: rtl/rf_wb_arbiter_if.sv
// Writeback port bundle between the two writeback sources, the issue logic and rf_wb_arbiter.
// slave is the arbiter side; master is the side that drives requests and reservations.
interface rf_wb_arbiter_if #(
  parameter int PW = 3,
  parameter int DW = 8
);
  logic            alu_valid;
  logic            alu_ready;
  logic [PW-1:0]   alu_addr;
  logic [DW-1:0]   alu_data;
  logic            alu_scry;
  logic            alu_ngtv;
  logic            alu_zero;

  logic            ld_valid;
  logic            ld_ready;
  logic [PW-1:0]   ld_addr;
  logic [DW-1:0]   ld_data;

  logic            rsv_en;
  logic [PW-1:0]   rsv_addr;
  logic [2**PW-1:0] busy;

  logic            rf_we;
  logic [PW-1:0]   rf_addr;
  logic [DW-1:0]   rf_data;
  logic            rf_scry;
  logic            rf_ngtv;
  logic            rf_zero;

  modport slave (
    input  alu_valid, alu_addr, alu_data, alu_scry, alu_ngtv, alu_zero,
    output alu_ready,
    input  ld_valid, ld_addr, ld_data,
    output ld_ready,
    input  rsv_en, rsv_addr,
    output busy,
    output rf_we, rf_addr, rf_data, rf_scry, rf_ngtv, rf_zero
  );

  modport master (
    output alu_valid, alu_addr, alu_data, alu_scry, alu_ngtv, alu_zero,
    input  alu_ready,
    output ld_valid, ld_addr, ld_data,
    input  ld_ready,
    output rsv_en, rsv_addr,
    input  busy,
    input  rf_we, rf_addr, rf_data, rf_scry, rf_ngtv, rf_zero
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter (ALU vs load) with flag shadow and per-register busy scoreboard.
// Define RF_WB_RR_EN for round-robin conflict resolution; otherwise the ALU always wins conflicts.
module rf_wb_arbiter #(
  parameter int PW = 3,
  parameter int DW = 8
) (
  input logic            clk,
  input logic            reset,
  rf_wb_arbiter_if.slave bus
);

  localparam int NR = 2**PW;

  logic          alu_grant;
  logic          ld_grant;
  logic          conflict;

  logic          rf_we_q, rf_we_d;
  logic [PW-1:0] rf_addr_q, rf_addr_d;
  logic [DW-1:0] rf_data_q, rf_data_d;
  logic [2:0]    rf_flags_q, rf_flags_d;
  logic [2:0]    shadow_q, shadow_d;
  logic [NR-1:0] busy_q, busy_d;

  assign conflict = reset && bus.alu_valid && bus.ld_valid;

`ifdef RF_WB_RR_EN
  typedef enum logic {
    PREF_ALU = 1'b0,
    PREF_LD  = 1'b1
  } pref_e;

  pref_e pref_q, pref_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pref_q <= PREF_ALU;
    else        pref_q <= pref_d;
  end

  // The source that just won a conflict yields the next one.
  always_comb begin
    pref_d    = pref_q;
    alu_grant = 1'b0;
    ld_grant  = 1'b0;
    if (conflict) begin
      alu_grant = (pref_q == PREF_ALU);
      ld_grant  = (pref_q == PREF_LD);
      pref_d    = (pref_q == PREF_ALU) ? PREF_LD : PREF_ALU;
    end else if (reset) begin
      alu_grant = bus.alu_valid;
      ld_grant  = bus.ld_valid;
    end
  end
`else
  always_comb begin
    alu_grant = 1'b0;
    ld_grant  = 1'b0;
    if (reset) begin
      alu_grant = bus.alu_valid;
      ld_grant  = bus.ld_valid && !bus.alu_valid;
    end
  end
`endif

  // Loads reuse the shadow flags so only ALU results ever change the flag state.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_addr_d  = rf_addr_q;
    rf_data_d  = rf_data_q;
    rf_flags_d = rf_flags_q;
    shadow_d   = shadow_q;
    if (alu_grant) begin
      rf_we_d    = 1'b1;
      rf_addr_d  = bus.alu_addr;
      rf_data_d  = bus.alu_data;
      rf_flags_d = {bus.alu_scry, bus.alu_ngtv, bus.alu_zero};
      shadow_d   = {bus.alu_scry, bus.alu_ngtv, bus.alu_zero};
    end else if (ld_grant) begin
      rf_we_d    = 1'b1;
      rf_addr_d  = bus.ld_addr;
      rf_data_d  = bus.ld_data;
      rf_flags_d = shadow_q;
    end
  end

  // Clear is applied before set so a same-cycle reservation keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q) busy_d[rf_addr_q] = 1'b0;
    if (bus.rsv_en) busy_d[bus.rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
      rf_flags_q <= '0;
      shadow_q   <= '0;
      busy_q     <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
      rf_flags_q <= rf_flags_d;
      shadow_q   <= shadow_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.alu_ready = alu_grant;
  assign bus.ld_ready  = ld_grant;
  assign bus.busy      = busy_q;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_addr   = rf_addr_q;
  assign bus.rf_data   = rf_data_q;
  assign bus.rf_scry   = rf_flags_q[2];
  assign bus.rf_ngtv   = rf_flags_q[1];
  assign bus.rf_zero   = rf_flags_q[0];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model (RF_WB_RR_EN selects the arbitration model).
module tb_rf_wb_arbiter;

  localparam int PW = 3;
  localparam int DW = 8;
  localparam int NR = 2**PW;

  logic clk;
  logic reset;

  int checks = 0;
  int errors = 0;
  bit check_en = 0;

  rf_wb_arbiter_if #(.PW(PW), .DW(DW)) bus ();

  rf_wb_arbiter #(.PW(PW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: what the register file port must show, and which registers are pending.
  bit            m_ld_won_last = 1'b1;
  bit            m_we = 1'b0;
  logic [PW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [2:0]    m_flags = '0;
  logic [2:0]    m_shadow = '0;
  bit            m_busy [NR];

  function automatic bit alu_wins_conflict();
`ifdef RF_WB_RR_EN
    return m_ld_won_last;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic exp_alu_grant();
    return reset && bus.alu_valid && (!bus.ld_valid || alu_wins_conflict());
  endfunction

  function automatic logic exp_ld_grant();
    return reset && bus.ld_valid && !(bus.alu_valid && alu_wins_conflict());
  endfunction

  function automatic logic [NR-1:0] model_busy_vec();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      m_ld_won_last = 1'b1;
      m_we = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_flags = '0;
      m_shadow = '0;
      for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
    end else begin
      logic ga, gl;
      ga = exp_alu_grant();
      gl = exp_ld_grant();
      if (bus.alu_valid && bus.ld_valid) m_ld_won_last = gl;
      if (m_we) m_busy[m_addr] = 1'b0;
      if (bus.rsv_en) m_busy[bus.rsv_addr] = 1'b1;
      m_we = ga || gl;
      if (ga) begin
        m_addr = bus.alu_addr;
        m_data = bus.alu_data;
        m_flags = {bus.alu_scry, bus.alu_ngtv, bus.alu_zero};
        m_shadow = m_flags;
      end else if (gl) begin
        m_addr = bus.ld_addr;
        m_data = bus.ld_data;
        m_flags = m_shadow;
      end
    end
  end

  // Every cycle: compare readies and the registered port against the model mid-cycle.
  always @(negedge clk) begin
    if (check_en) begin
      if (!reset) begin
        checkOutput("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
        checkOutput("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
        checkOutput("rst_rf_we", 32'(bus.rf_we), 32'd0);
        checkOutput("rst_rf_data", 32'(bus.rf_data), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
      end else begin
        checkOutput("alu_ready", 32'(bus.alu_ready), 32'(exp_alu_grant()));
        checkOutput("ld_ready", 32'(bus.ld_ready), 32'(exp_ld_grant()));
        checkOutput("rf_we", 32'(bus.rf_we), 32'(m_we));
        checkOutput("rf_addr", 32'(bus.rf_addr), 32'(m_addr));
        checkOutput("rf_data", 32'(bus.rf_data), 32'(m_data));
        checkOutput("rf_flags", 32'({bus.rf_scry, bus.rf_ngtv, bus.rf_zero}), 32'(m_flags));
        checkOutput("busy", 32'(bus.busy), 32'(model_busy_vec()));
      end
    end
  end

  task automatic applyStimulus(
    input logic          rs,
    input logic          av,
    input logic [PW-1:0] aa,
    input logic [DW-1:0] ad,
    input logic [2:0]    af,
    input logic          lv,
    input logic [PW-1:0] la,
    input logic [DW-1:0] ldat,
    input logic          rv,
    input logic [PW-1:0] ra
  );
    @(posedge clk);
    #2;
    reset         = rs;
    bus.alu_valid = av;
    bus.alu_addr  = aa;
    bus.alu_data  = ad;
    {bus.alu_scry, bus.alu_ngtv, bus.alu_zero} = af;
    bus.ld_valid  = lv;
    bus.ld_addr   = la;
    bus.ld_data   = ldat;
    bus.rsv_en    = rv;
    bus.rsv_addr  = ra;
    check_en      = 1'b1;
  endtask

  task automatic idle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic mid_cycle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    bus.alu_valid = 0; bus.alu_addr = 0; bus.alu_data = 0;
    bus.alu_scry = 0; bus.alu_ngtv = 0; bus.alu_zero = 0;
    bus.ld_valid = 0; bus.ld_addr = 0; bus.ld_data = 0;
    bus.rsv_en = 0; bus.rsv_addr = 0;

    // Reset with both sources requesting.
    applyStimulus(0, 1, 3'd1, 8'hFF, 3'b111, 1, 3'd2, 8'hEE, 1, 3'd4);
    mid_cycle();
    checkOutput("lit_reset_alu_ready", 32'(bus.alu_ready), 32'd0);
    checkOutput("lit_reset_ld_ready", 32'(bus.ld_ready), 32'd0);
    checkOutput("lit_reset_rf_we", 32'(bus.rf_we), 32'd0);
    checkOutput("lit_reset_busy", 32'(bus.busy), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Single ALU write, then an ALU write setting ngtv, then a load.
    applyStimulus(1, 1, 3'd3, 8'h5A, 3'b001, 0, 0, 0, 0, 0);
    mid_cycle();
    checkOutput("lit_alu_ready", 32'(bus.alu_ready), 32'd1);
    applyStimulus(1, 1, 3'd1, 8'h80, 3'b010, 0, 0, 0, 0, 0);
    mid_cycle();
    checkOutput("lit_alu_rf_we", 32'(bus.rf_we), 32'd1);
    checkOutput("lit_alu_rf_addr", 32'(bus.rf_addr), 32'd3);
    checkOutput("lit_alu_rf_data", 32'(bus.rf_data), 32'h5A);
    checkOutput("lit_alu_rf_zero", 32'(bus.rf_zero), 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 1, 3'd2, 8'h11, 0, 0);
    mid_cycle();
    checkOutput("lit_ld_ready", 32'(bus.ld_ready), 32'd1);
    idle();
    mid_cycle();
    checkOutput("lit_ld_rf_addr", 32'(bus.rf_addr), 32'd2);
    checkOutput("lit_ld_rf_data", 32'(bus.rf_data), 32'h11);
    checkOutput("lit_ld_rf_ngtv", 32'(bus.rf_ngtv), 32'd1);
    checkOutput("lit_ld_rf_zero", 32'(bus.rf_zero), 32'd0);

    // Three conflict cycles.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 3'd4, 8'hA0, 3'b000, 1, 3'd6, 8'hB0, 0, 0);
      mid_cycle();
`ifdef RF_WB_RR_EN
      checkOutput("lit_conflict_alu_ready", 32'(bus.alu_ready), (i == 1) ? 32'd0 : 32'd1);
      checkOutput("lit_conflict_ld_ready", 32'(bus.ld_ready), (i == 1) ? 32'd1 : 32'd0);
`else
      checkOutput("lit_conflict_alu_ready", 32'(bus.alu_ready), 32'd1);
      checkOutput("lit_conflict_ld_ready", 32'(bus.ld_ready), 32'd0);
`endif
    end
    idle();

    // Reserve r5, load r5 two cycles later, watch busy[5] rise and clear.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 3'd5);
    idle();
    mid_cycle();
    checkOutput("lit_busy5_set", 32'(bus.busy[5]), 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 1, 3'd5, 8'h55, 0, 0);
    idle();
    mid_cycle();
    checkOutput("lit_busy5_during_write", 32'(bus.busy[5]), 32'd1);
    idle();
    mid_cycle();
    checkOutput("lit_busy5_cleared", 32'(bus.busy[5]), 32'd0);

    // Reservation in the same cycle r5 is written keeps it busy.
    applyStimulus(1, 1, 3'd5, 8'h66, 3'b100, 0, 0, 0, 1, 3'd5);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 3'd5);
    mid_cycle();
    checkOutput("lit_same_cycle_rf_we", 32'(bus.rf_we), 32'd1);
    idle();
    mid_cycle();
    checkOutput("lit_set_wins_busy5", 32'(bus.busy[5]), 32'd1);

    // Reset while a granted write is in flight.
    applyStimulus(1, 1, 3'd7, 8'h77, 3'b111, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mid_cycle();
    checkOutput("lit_midreset_rf_we", 32'(bus.rf_we), 32'd0);
    checkOutput("lit_midreset_busy", 32'(bus.busy), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic, checked each cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(
        ($urandom_range(99) != 0),
        ($urandom_range(9) < 6),
        PW'($urandom_range(NR - 1)),
        DW'($urandom),
        3'($urandom_range(7)),
        ($urandom_range(9) < 6),
        PW'($urandom_range(NR - 1)),
        DW'($urandom),
        ($urandom_range(9) < 3),
        PW'($urandom_range(NR - 1))
      );
    end
    idle();
    mid_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Writeback arbiter and reservation scoreboard for the 8-bit register file. Shares the register file's single write port between the ALU writeback source and the load-data source using a valid/ready handshake and drives the port from a registered output stage. Keeps a shadow copy of the last ALU flags so load writebacks never corrupt the flags. Tracks per-register busy bits so the issue logic can stall on pending writes.

## Interface
- PW, 3, register address width; 2**PW registers
- DW, 8, data width
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- alu_valid  input  1  ALU writeback request
- alu_ready  output  1  ALU request granted this cycle (combinational)
- alu_addr  input  PW  ALU destination register
- alu_data  input  DW  ALU result
- alu_scry, alu_ngtv, alu_zero  input  1 each  ALU flag results
- ld_valid  input  1  load writeback request
- ld_ready  output  1  load request granted this cycle (combinational)
- ld_addr  input  PW  load destination register
- ld_data  input  DW  load data
- rsv_en  input  1  issue logic reserves a destination register
- rsv_addr  input  PW  register being reserved
- busy  output  2**PW  bit i = register i has a pending write
- rf_we  output  1  register file write enable
- rf_addr  output  PW  register file write address
- rf_data  output  DW  register file write data
- rf_scry, rf_ngtv, rf_zero  output  1 each  flag values presented to the register file

## Operation
- Register file has no flag-only write enable: every rf_we writes flags, so arbiter always presents correct flag values.
- Arbitration per cycle: only one valid -> that source granted. Both valid -> winner per Configuration. Neither -> no grant.
- Output stage is never back-pressured: a granted request is always accepted; ready = grant, a transfer occurs when valid && ready.
- Accepted ALU write: output stage loads alu_addr/alu_data, rf flags = alu flags, shadow flags updated to alu flags.
- Accepted load write: output stage loads ld_addr/ld_data, rf flags = shadow flags (unchanged).
- No transfer: rf_we = 0 next cycle; rf_addr/rf_data/flags hold previous values.
- Scoreboard: rsv_en sets busy[rsv_addr] at next edge. Cycle with rf_we = 1 clears busy[rf_addr] at that edge.
- Simultaneous set and clear of same register: set wins (busy stays 1).
- Reserving an already-busy register: stays 1 (no counting). Write to non-busy register: permitted, busy stays 0.
- Address width arithmetic: addresses used directly as indices, no wrap logic; all 2**PW registers valid.
- Reset (asserted): rf_we, rf_addr, rf_data, rf flags, shadow flags, busy all 0; arbitration pointer to ALU-favoured. alu_ready/ld_ready are 0 while reset is asserted. Reset mid-transfer drops the in-flight write; no write reaches the register file.

## Timing
- Request in cycle T with ready = 1 -> rf_we = 1 with its addr/data during T+1 -> register file captures at end of T+1.
- Busy clears at end of T+1, same edge the register file is written; reads of that register are valid from T+2.
- Reservation in cycle T -> busy visible in T+1.
- Throughput: one writeback per cycle, any mix of sources.
- Reset deassertion synchronised externally; first grant possible in first cycle after release.

## Configuration
- RF_WB_RR_EN defined: round-robin on conflict. Pointer records last conflict winner; next conflict grants the other source. Pointer updates only on conflict cycles. After reset, ALU wins first conflict.
- RF_WB_RR_EN undefined: fixed priority, ALU always wins conflicts; load may starve under continuous ALU traffic (accepted behaviour). Pointer logic absent.

## Test plan
- Reset: drive reset = 0 with both valids high -> all outputs 0, both readies 0, busy = 0.
- Single ALU write: alu_valid, addr 3, data 0x5A, zero = 1 at T -> alu_ready = 1 at T; T+1 rf_we = 1, rf_addr = 3, rf_data = 0x5A, rf_zero = 1.
- Flag preservation: ALU write with ngtv = 1, then load addr 2 data 0x11 -> load cycle rf_ngtv = 1, rf_data = 0x11.
- Conflict: both valid for 3 cycles -> RR: grants ALU, LD, ALU; fixed: ALU ×3, ld_ready = 0.
- Scoreboard: rsv_en addr 5 at T -> busy[5] = 1 at T+1; load addr 5 at T+2 -> busy[5] = 0 at T+4; rsv_en addr 5 in same cycle as rf_we addr 5 -> busy[5] stays 1.
- Reset mid-operation: ALU granted at T, reset asserted in T+1 -> rf_we = 0 immediately, busy cleared.
